// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one decryption round per clock over a 128-bit state.
// Key schedule is expanded combinationally from the key latched at block acceptance.
module aes_decrypt_iter #(
    parameter int key_length = 128,
    parameter int Nk         = key_length / 32,
    parameter int Nr         = Nk + 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:127]          cipher_txt,
    input  logic [0:key_length-1] key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:127]          plain_txt,
    output logic                  busy
);

    localparam int RW = $clog2(Nr);
    localparam int NW = 4 * (Nr + 1);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t                  fsm, fsm_next;
    logic [0:127]          state;
    logic [0:key_length-1] key_reg;
    logic [RW-1:0]         rnd;

    function automatic logic [7:0] sub(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ m;
            m = xtime(m);
        end
        return p;
    endfunction

    function automatic logic [0:NW*32-1] expand(input logic [0:key_length-1] k);
        logic [0:NW*32-1] w;
        logic [31:0]      t;
        logic [7:0]       rcon;
        w    = '0;
        rcon = 8'h01;
        for (int i = 0; i < Nk; i++) w[32*i +: 32] = k[32*i +: 32];
        for (int i = Nk; i < NW; i++) begin
            t = w[32*(i-1) +: 32];
            if (i % Nk == 0) begin
                t    = {sub(t[23:16]), sub(t[15:8]), sub(t[7:0]), sub(t[31:24])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = {sub(t[31:24]), sub(t[23:16]), sub(t[15:8]), sub(t[7:0])};
            end
            w[32*i +: 32] = w[32*(i-Nk) +: 32] ^ t;
        end
        return w;
    endfunction

    // Byte b of the block sits at bits [8b +: 8]; b = 4*column + row.
    function automatic logic [0:127] inv_shift_sub(input logic [0:127] s);
        logic [0:127] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(4*c+r) +: 8] = INV_SBOX[{s[8*(4*((c-r+4)%4)+r) +: 8], 3'b000} +: 8];
        return o;
    endfunction

    function automatic logic [0:127] inv_mix(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c    +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[32*c+8  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[32*c+16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[32*c+24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    logic [0:NW*32-1] ks;
    logic [0:127]     rkey, pre_mix, round_out;
    int               rk_idx;

    // In IDLE the schedule follows the live key input so round key Nr is ready on the accept edge.
    assign ks = expand((fsm == IDLE) ? key : key_reg);

    always_comb begin
        rk_idx    = (fsm == IDLE) ? Nr : int'(rnd);
        rkey      = ks[128*rk_idx +: 128];
        pre_mix   = inv_shift_sub(state) ^ rkey;
        round_out = (rnd == '0) ? pre_mix : inv_mix(pre_mix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_next = ROUND;
            ROUND:   if (rnd == '0) fsm_next = DONE;
            DONE:    if (out_ready) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= '0;
            key_reg <= '0;
            rnd     <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    key_reg <= key;
                    state   <= cipher_txt ^ rkey;
                    rnd     <= RW'(Nr - 1);
                end
                ROUND: begin
                    state <= round_out;
                    if (rnd != '0) rnd <= rnd - RW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign plain_txt = state;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: AES-128/192/256 instances, scoreboard fed by an
// independent forward-cipher model (S-box derived from GF(2^8) inversion).
module tb_aes_decrypt_iter;

    typedef struct packed {
        logic [1:0]   inst;
        int           acc;
        logic [127:0] pt;
    } exp_t;

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid_a [3];
    logic         in_ready_a [3];
    logic         out_valid_a[3];
    logic         busy_a     [3];
    logic [127:0] plain_a    [3];
    logic [127:0] cipher;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic         out_ready;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   ordy_mode = 1;
    exp_t exp_q[$];
    logic [7:0] m_sbox[256];

    aes_decrypt_iter #(.key_length(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .cipher_txt(cipher), .key(key128), .out_valid(out_valid_a[0]), .out_ready(out_ready),
        .plain_txt(plain_a[0]), .busy(busy_a[0]));

    aes_decrypt_iter #(.key_length(192)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .cipher_txt(cipher), .key(key192), .out_valid(out_valid_a[1]), .out_ready(out_ready),
        .plain_txt(plain_a[1]), .busy(busy_a[1]));

    aes_decrypt_iter #(.key_length(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .cipher_txt(cipher), .key(key256), .out_valid(out_valid_a[2]), .out_ready(out_ready),
        .plain_txt(plain_a[2]), .busy(busy_a[2]));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        case (ordy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] m = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            m_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [255:0] key, input int nk,
                                                   input logic [127:0] pt);
        logic [7:0]   ek[240];
        logic [7:0]   s[16];
        logic [7:0]   n[16];
        logic [7:0]   t[4];
        logic [7:0]   rc, tmp, a0, a1, a2, a3;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int j = 0; j < 4 * nk; j++) ek[j] = key[255 - 8*j -: 8];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            for (int j = 0; j < 4; j++) t[j] = ek[4*(i-1) + j];
            if (i % nk == 0) begin
                tmp  = t[0];
                t[0] = m_sbox[t[1]] ^ rc;
                t[1] = m_sbox[t[2]];
                t[2] = m_sbox[t[3]];
                t[3] = m_sbox[tmp];
                rc   = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = m_sbox[t[j]];
            end
            for (int j = 0; j < 4; j++) ek[4*i + j] = ek[4*(i-nk) + j] ^ t[j];
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ ek[b];
        for (int r = 1; r <= nr; r++) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    n[4*c + row] = m_sbox[s[4*((c + row) % 4) + row]];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                    s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end else begin
                s = n;
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ ek[16*r + b];
        end
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
        return res;
    endfunction

    // ---------------- scoreboard helpers ----------------
    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int inst, input logic [255:0] k, input logic [127:0] ct,
                        input logic [127:0] pt);
        exp_t e;
        int   n = 0;
        while (!in_ready_a[inst] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready_a[inst]) begin
            check("send_timeout", 128'(in_ready_a[inst]), 128'd1);
            return;
        end
        key128 = k[255:128];
        key192 = k[255:64];
        key256 = k;
        cipher = ct;
        in_valid_a[inst] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[inst] = 1'b0;
        e.inst = 2'(inst);
        e.acc  = cyc;
        e.pt   = pt;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy_a[0] || busy_a[1] || busy_a[2]) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 128'(n >= 3000), 128'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic         ov_prev[3];
        logic [127:0] pt_prev[3];
        int           first[3];
        int           idx;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    ov_prev[i] = 1'b0;
                end else begin
                    if (out_valid_a[i]) begin
                        if (!ov_prev[i]) first[i] = cyc;
                        else check("hold_stable", plain_a[i], pt_prev[i]);
                        check("done_in_ready", 128'(in_ready_a[i]), 128'd0);
                        check("done_busy", 128'(busy_a[i]), 128'd1);
                        if (out_ready) begin
                            idx = -1;
                            for (int j = 0; j < exp_q.size(); j++)
                                if (idx < 0 && exp_q[j].inst == 2'(i)) idx = j;
                            if (idx < 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected_output inst %0d: got %h, required no output", i, plain_a[i]);
                            end else begin
                                check("plain_txt", plain_a[i], exp_q[idx].pt);
                                check("latency", 128'(first[i] - exp_q[idx].acc), 128'(10 + 2*i));
                                exp_q.delete(idx);
                                n_pop++;
                            end
                        end
                    end
                    ov_prev[i] = out_valid_a[i];
                    pt_prev[i] = plain_a[i];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] rk;
        logic [127:0] rp;
        int           inst;
        int           n;
        build_sbox();
        for (int i = 0; i < 3; i++) in_valid_a[i] = 1'b0;
        cipher = '0; key128 = '0; key192 = '0; key256 = '0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", 128'(out_valid_a[i]), 128'd0);
            check("rst_plain", plain_a[i], 128'd0);
            check("rst_in_ready", 128'(in_ready_a[i]), 128'd1);
            check("rst_busy", 128'(busy_a[i]), 128'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-answer vectors for all three key sizes
        send(0, K1, C1, PT); wait_drain();
        send(1, K2, C2, PT); wait_drain();
        send(2, K3, C3, PT); wait_drain();

        // Backpressure in DONE
        ordy_mode = 0;
        send(0, K1, C1, PT);
        n = 0;
        while (!out_valid_a[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid_seen", 128'(out_valid_a[0]), 128'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 128'(out_valid_a[0]), 128'd1);
        end
        ordy_mode = 1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", 128'(in_ready_a[0]), 128'd1);
        check("bp_valid_dropped", 128'(out_valid_a[0]), 128'd0);
        wait_drain();

        // Asynchronous reset in the middle of the round sequence
        send(0, K1, C1, PT);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid_a[0]), 128'd0);
        check("midrst_plain", plain_a[0], 128'd0);
        check("midrst_in_ready", 128'(in_ready_a[0]), 128'd1);
        check("midrst_busy", 128'(busy_a[0]), 128'd0);
        exp_q.delete();
        n_push = n_pop;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, K1, C1, PT); wait_drain();

        // Inputs change and in_valid pulses while rounds are running
        send(0, K1, C1, PT);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            cipher = {$urandom, $urandom, $urandom, $urandom};
            key128 = {$urandom, $urandom, $urandom, $urandom};
            in_valid_a[0] = (k == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end
        in_valid_a[0] = 1'b0;
        wait_drain();

        // Random round trips with input gaps and output backpressure
        ordy_mode = 2;
        for (int t = 0; t < 200; t++) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            inst = $urandom_range(0, 2);
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            send(inst, rk, model_encrypt(rk, 4 + 2*inst, rp), rp);
        end
        wait_drain();
        ordy_mode = 1;

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        check("handshake_count", 128'(n_pop), 128'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative AES decryptor (FIPS-197 inverse cipher) that performs one decryption round per clock over a 128-bit state register. It is the receive-side counterpart to the combinational encrypt datapath and sits behind a valid/ready input stream of ciphertext blocks and in front of a valid/ready plaintext output stream. The key schedule is expanded combinationally from a key register latched at block acceptance. One block is processed at a time.

## Interface
- key_length, 128: key width in bits (128/192/256).
- Nk, 4: key words (4/6/8); must equal key_length/32.
- Nr, Nk+6: number of rounds (10/12/14).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  cipher_txt/key valid.
- in_ready  output  1  block can be accepted; high only in IDLE.
- cipher_txt  input  [0:127]  ciphertext block; bit 0 = MSB of byte 0, bytes column-major.
- key  input  [0:key_length-1]  cipher key, same ordering.
- out_valid  output  1  plain_txt valid; high only in DONE.
- out_ready  input  1  downstream accepts plain_txt.
- plain_txt  output  [0:127]  recovered plaintext, driven from the state register.
- busy  output  1  high in ROUND or DONE.

## Operation
- One clock (clk); reset is asynchronous, active-low (rst_n).
- FSM states: IDLE, ROUND, DONE.
- Accept = in_valid && in_ready in IDLE. On accept:
  - key_reg <= key.
  - state <= cipher_txt ^ w[Nr], using the expansion of the key input this cycle.
  - rnd <= Nr-1.
  - go to ROUND.
- Expanded key w[0..Nr] comes from Key_Expansion #(.Nk(Nk)) driven by key_reg. On the accept cycle only, round key Nr comes from a second expansion of the key input, or equivalently from a mux onto the same instance's input.
- ROUND with rnd >= 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ w[rnd]); rnd <= rnd-1.
- ROUND with rnd == 0: state <= InvSubBytes(InvShiftRows(state)) ^ w[0]; go to DONE.
- InvShiftRows and InvMixColumns use the ShiftRows/MixColumns modules with enc_dec=1. The inverse S-box is a local 256-entry lookup applied to all 16 bytes.
- DONE: out_valid=1 and plain_txt = state, both held stable. If out_ready is high, go to IDLE.
- in_valid while busy is ignored and no value is sampled. cipher_txt/key changes after accept have no effect.
- rnd is ceil(log2(Nr)) bits wide and never wraps. The rnd==0 check ends the sequence.
- Reset values: state 0, key_reg 0, rnd 0, FSM IDLE. So plain_txt=0, out_valid=0, busy=0, in_ready=1.
- Reset asserted mid-operation aborts the block: no out_valid, everything returns to reset values immediately.

## Timing
- Accept edge E0; round edges E1..ENr; out_valid rises after ENr.
- Latency is Nr cycles from the accept cycle to first out_valid cycle: 10/12/14.
- The output handshake completes at the edge where out_valid && out_ready. in_ready is high the following cycle.
- Minimum block period is Nr+2 cycles: accept, Nr rounds, DONE with out_ready=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- in_ready and out_valid are decoded from the FSM register only.

## Test plan
- FIPS-197 C.1, AES-128: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: plain_txt 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept.
- C.3, Nk=8: key 000102…1f, cipher 8ea2b7ca516745bfeafc49904b496089.
  - Required: same plaintext, latency 14. C.2 with Nk=6 (cipher dda97ca4864cdfe06eaf70a0ec0d7191) gives latency 12.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: plain_txt and out_valid stable, in_ready=0, then IDLE one cycle after out_ready=1.
- Reset mid-operation: deassert rst_n at round 4, asynchronously.
  - Required: out_valid=0, plain_txt=0, in_ready=1 immediately.
  - Then decrypt C.1 again and get the correct result.
- Input-change robustness: change cipher_txt/key and pulse in_valid during ROUND.
  - Required: result equals the originally accepted block, and exactly one output handshake.
- Random round-trip: 200 random key/plaintext pairs encrypted by the golden model, streamed with random in_valid/out_ready gaps.
  - Required: every plain_txt matches, in order.
